// File: rtl/exe_wb_buffer.sv
// Two-entry elastic buffer between exe and writeback; wb_* and exe_ready_o come from flops only.
// Optional operand bypass of the youngest writing entry, enabled by defining EXE_WB_BYPASS_EN.
module exe_wb_buffer #(
    parameter int XLEN  = 64,
    parameter int PC_W  = 64,
    parameter int REG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             kill_i,
    input  logic             exe_valid_i,
    output logic             exe_ready_o,
    input  logic [REG_W-1:0] exe_rd_i,
    input  logic             exe_we_i,
    input  logic [XLEN-1:0]  exe_result_i,
    input  logic [PC_W-1:0]  exe_pc_i,
    input  logic             exe_xcpt_i,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [REG_W-1:0] wb_rd_o,
    output logic             wb_we_o,
    output logic [XLEN-1:0]  wb_result_o,
    output logic [PC_W-1:0]  wb_pc_o,
    output logic             wb_xcpt_o,
    output logic             byp_valid_o,
    output logic [REG_W-1:0] byp_rd_o,
    output logic [XLEN-1:0]  byp_data_o,
    output logic [1:0]       occupancy_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // a valid producer holds its payload until accepted, and ready never looks at valid.

    typedef struct packed {
        logic             xcpt;
        logic [PC_W-1:0]  pc;
        logic [XLEN-1:0]  result;
        logic             we;
        logic [REG_W-1:0] rd;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    entry_t head;
    entry_t tail;
    entry_t incoming;
    logic   push;
    logic   pop;

    assign exe_ready_o = (state != FULL);
    assign wb_valid_o  = (state != EMPTY);
    assign push        = exe_valid_i & exe_ready_o;
    assign pop         = wb_valid_o & wb_ready_i;
    assign occupancy_o = state;

    // Writes to x0 and from excepting instructions are squashed before storage.
    always_comb begin
        incoming.xcpt   = exe_xcpt_i;
        incoming.pc     = exe_pc_i;
        incoming.result = exe_result_i;
        incoming.we     = exe_we_i & (exe_rd_i != '0) & ~exe_xcpt_i;
        incoming.rd     = exe_rd_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else if (kill_i) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head  <= incoming;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head <= incoming;
                    end else if (push) begin
                        tail  <= incoming;
                        state <= FULL;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head  <= tail;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign wb_rd_o     = head.rd;
    assign wb_we_o     = head.we;
    assign wb_result_o = head.result;
    assign wb_pc_o     = head.pc;
    assign wb_xcpt_o   = head.xcpt;

`ifdef EXE_WB_BYPASS_EN
    // Youngest writing entry wins, so the tail beats the head when both write.
    always_comb begin
        byp_valid_o = 1'b0;
        byp_rd_o    = '0;
        byp_data_o  = '0;
        if (state == FULL && tail.we) begin
            byp_valid_o = 1'b1;
            byp_rd_o    = tail.rd;
            byp_data_o  = tail.result;
        end else if (state != EMPTY && head.we) begin
            byp_valid_o = 1'b1;
            byp_rd_o    = head.rd;
            byp_data_o  = head.result;
        end
    end
`else
    assign byp_valid_o = 1'b0;
    assign byp_rd_o    = '0;
    assign byp_data_o  = '0;
`endif

endmodule
